// File: rtl/reduce_rows_pipe.sv
// reduce_rows_pipe: registered FANIN-ary reduction tree (OR/AND/XOR) over ROWS column vectors
// with end-to-end valid/ready. Defining REDUCE_ROWS_FLUSH_EN adds a synchronous flush port.
module reduce_rows_pipe #(
    parameter int ROWS  = 8,
    parameter int COLS  = 2,
    parameter int FANIN = 2,
    parameter int MODE  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [COLS-1:0] in_data [ROWS],
`ifdef REDUCE_ROWS_FLUSH_EN
    input  logic            flush,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [COLS-1:0] out_data
);

    // Number of partial vectors left after lvl tree levels.
    function automatic int level_width(input int lvl);
        int n;
        n = ROWS;
        for (int i = 0; i < lvl; i++) n = (n + FANIN - 1) / FANIN;
        return n;
    endfunction

    function automatic int calc_nstage();
        int n;
        int s;
        n = ROWS;
        s = 0;
        for (int i = 0; i < ROWS && n > 1; i++) begin
            n = (n + FANIN - 1) / FANIN;
            s++;
        end
        return (s < 1) ? 1 : s;
    endfunction

    function automatic logic [COLS-1:0] combine(input logic [COLS-1:0] a, input logic [COLS-1:0] b);
        case (MODE)
            1:       return a & b;
            2:       return a ^ b;
            default: return a | b;
        endcase
    endfunction

    localparam int NSTAGE = calc_nstage();
    localparam logic [COLS-1:0] IDENT = (MODE == 1) ? {COLS{1'b1}} : {COLS{1'b0}};

    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("reduce_rows_pipe: MODE must be 0 (OR), 1 (AND) or 2 (XOR)");
    end
    if (ROWS < 1 || COLS < 1 || FANIN < 2) begin : g_bad_shape
        $error("reduce_rows_pipe: need ROWS >= 1, COLS >= 1, FANIN >= 2");
    end

    logic [NSTAGE-1:0] v;
    logic [NSTAGE-1:0] vin;
    logic [NSTAGE-1:0] rdy;
    logic [NSTAGE-1:0] load;
    logic              clr;
    logic              tail_full;
    int                idx;
    logic [COLS-1:0]   acc;

    // Only the first level_width(k+1) entries of stage k carry data; the rest fold to IDENT.
    logic [COLS-1:0] src [NSTAGE][ROWS];
    logic [COLS-1:0] red [NSTAGE][ROWS];
    logic [COLS-1:0] q   [NSTAGE][ROWS];

`ifdef REDUCE_ROWS_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // A stage is ready when it or anything between it and the output has a free slot.
    always_comb begin
        rdy       = '0;
        vin       = '0;
        load      = '0;
        tail_full = 1'b1;
        for (int i = 0; i < NSTAGE; i++) begin
            tail_full = 1'b1;
            for (int j = i; j < NSTAGE; j++) tail_full = tail_full & v[j];
            rdy[i] = out_ready | ~tail_full;
        end
        vin[0] = in_valid;
        for (int i = 1; i < NSTAGE; i++) vin[i] = v[i-1];
        for (int i = 0; i < NSTAGE; i++) load[i] = rdy[i] & vin[i] & ~clr;
    end

    always_comb begin
        idx = 0;
        acc = IDENT;
        for (int r = 0; r < ROWS; r++) src[0][r] = in_data[r];
        for (int k = 1; k < NSTAGE; k++)
            for (int r = 0; r < ROWS; r++) src[k][r] = q[k-1][r];
        for (int k = 0; k < NSTAGE; k++) begin
            for (int o = 0; o < ROWS; o++) begin
                acc = IDENT;
                for (int j = 0; j < FANIN; j++) begin
                    idx = o * FANIN + j;
                    if (idx < level_width(k)) acc = combine(acc, src[k][idx]);
                end
                red[k][o] = acc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
        end else if (clr) begin
            v <= '0;
        end else begin
            for (int i = 0; i < NSTAGE; i++)
                if (rdy[i]) v[i] <= vin[i];
        end
    end

    // Data only moves with a real token so a stalled result is never overwritten by a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTAGE; k++)
                for (int r = 0; r < ROWS; r++) q[k][r] <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++)
                if (load[k])
                    for (int r = 0; r < ROWS; r++) q[k][r] <= red[k][r];
        end
    end

    assign in_ready  = rdy[0] & ~clr;
    assign out_valid = v[NSTAGE-1];
    assign out_data  = q[NSTAGE-1][0];

endmodule

// File: tb/tb_reduce_rows_pipe.sv
// Bench for reduce_rows_pipe: single-shot latency/value tests on OR/AND/pass-through instances,
// randomized XOR streaming with back-pressure, mid-flight reset and (if enabled) flush.
module tb_reduce_rows_pipe;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic       s_in_valid;
    logic       s_out_ready;
    logic [3:0] s_rows [8];
    logic [3:0] b_rows [5];
    logic [3:0] c_rows [1];
`ifdef REDUCE_ROWS_FLUSH_EN
    logic       flush;
`endif

    always_comb begin
        for (int i = 0; i < 5; i++) b_rows[i] = s_rows[i];
        c_rows[0] = s_rows[0];
    end

    logic       a_in_ready, a_out_valid;
    logic [3:0] a_out_data;
    logic       b_in_ready, b_out_valid;
    logic [3:0] b_out_data;
    logic       c_in_ready, c_out_valid;
    logic [3:0] c_out_data;

    logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [7:0] d_rows [4];
    logic [7:0] d_out_data;

    reduce_rows_pipe #(.ROWS(8), .COLS(4), .FANIN(2), .MODE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(a_in_ready),
        .in_data(s_rows),
`ifdef REDUCE_ROWS_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(a_out_valid), .out_ready(s_out_ready), .out_data(a_out_data)
    );

    reduce_rows_pipe #(.ROWS(5), .COLS(4), .FANIN(2), .MODE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(b_in_ready),
        .in_data(b_rows),
`ifdef REDUCE_ROWS_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(b_out_valid), .out_ready(s_out_ready), .out_data(b_out_data)
    );

    reduce_rows_pipe #(.ROWS(1), .COLS(4), .FANIN(2), .MODE(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(c_in_ready),
        .in_data(c_rows),
`ifdef REDUCE_ROWS_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(c_out_valid), .out_ready(s_out_ready), .out_data(c_out_data)
    );

    reduce_rows_pipe #(.ROWS(4), .COLS(8), .FANIN(3), .MODE(2)) dut_d (
        .clk(clk), .reset_n(reset_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_rows),
`ifdef REDUCE_ROWS_FLUSH_EN
        .flush(1'b0),
`endif
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Flat column-wise fold of the first n rows; no tree, no pipeline.
    function automatic logic [7:0] ref_reduce(input int mode, input int n, input logic [7:0] rows [8]);
        logic [7:0] a;
        a = (mode == 1) ? 8'hFF : 8'h00;
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       a = a & rows[i];
                2:       a = a ^ rows[i];
                default: a = a | rows[i];
            endcase
        end
        return a;
    endfunction

    // One transaction into A/B/C from idle; measure latency and value of each result.
    task automatic applyStimulus(input string name);
        logic [7:0] r [8];
        logic [7:0] e;
        logic [3:0] dat_a, dat_b, dat_c;
        int lat_a, lat_b, lat_c;
        for (int i = 0; i < 8; i++) r[i] = {4'h0, s_rows[i]};
        dat_a = '0; dat_b = '0; dat_c = '0;
        lat_a = 0;  lat_b = 0;  lat_c = 0;
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        #1;
        checkOutput({name, "_ready_a"}, a_in_ready, 1);
        checkOutput({name, "_ready_b"}, b_in_ready, 1);
        checkOutput({name, "_ready_c"}, c_in_ready, 1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (a_out_valid && lat_a == 0) begin lat_a = n; dat_a = a_out_data; end
            if (b_out_valid && lat_b == 0) begin lat_b = n; dat_b = b_out_data; end
            if (c_out_valid && lat_c == 0) begin lat_c = n; dat_c = c_out_data; end
            @(posedge clk); #1;
        end
        checkOutput({name, "_lat_a"}, lat_a, 3);
        checkOutput({name, "_lat_b"}, lat_b, 3);
        checkOutput({name, "_lat_c"}, lat_c, 1);
        e = ref_reduce(0, 8, r);
        checkOutput({name, "_or_a"}, dat_a, {4'h0, e[3:0]});
        e = ref_reduce(1, 5, r);
        checkOutput({name, "_and_b"}, dat_b, {4'h0, e[3:0]});
        e = ref_reduce(1, 1, r);
        checkOutput({name, "_pass_c"}, dat_c, {4'h0, e[3:0]});
    endtask

    task automatic streamXor();
        logic [7:0] expq [$];
        logic [7:0] r [8];
        logic [7:0] held, exp_val;
        logic stall_prev, fire_in, fire_out;
        int occ, sent, got;
        occ = 0; sent = 0; got = 0;
        stall_prev = 1'b0; held = '0;
        d_in_valid = 1'b0;
        for (int cyc = 0; cyc < 2000 && got < 20; cyc++) begin
            d_out_ready = ($urandom_range(0, 2) != 0);
            if (!d_in_valid && sent < 20) begin
                for (int i = 0; i < 4; i++) d_rows[i] = 8'($urandom);
                d_in_valid = 1'b1;
            end
            #1;
            checkOutput("xor_in_ready", d_in_ready, !(occ == 2 && !d_out_ready));
            if (occ == 0) checkOutput("xor_idle_valid", d_out_valid, 0);
            if (stall_prev) begin
                checkOutput("xor_hold_valid", d_out_valid, 1);
                checkOutput("xor_hold_data", d_out_data, held);
            end
            fire_in  = d_in_valid && d_in_ready;
            fire_out = d_out_valid && d_out_ready;
            if (fire_out) begin
                if (expq.size() == 0) begin
                    checkOutput("xor_extra", d_out_valid, 0);
                end else begin
                    exp_val = expq.pop_front();
                    checkOutput("xor_data", d_out_data, exp_val);
                    got++;
                end
            end
            if (fire_in) begin
                for (int i = 0; i < 8; i++) r[i] = '0;
                for (int i = 0; i < 4; i++) r[i] = d_rows[i];
                exp_val = ref_reduce(2, 4, r);
                expq.push_back(exp_val);
                sent++;
            end
            occ = occ + int'(fire_in) - int'(fire_out);
            stall_prev = d_out_valid && !d_out_ready;
            held = d_out_data;
            @(posedge clk); #1;
            if (fire_in) d_in_valid = 1'b0;
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        checkOutput("xor_count", got, 20);
        checkOutput("xor_left", expq.size(), 0);
    endtask

    task automatic fillA(input int n);
        s_in_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) s_rows[i] = 4'($urandom);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
    endtask

    task automatic watchA(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            seen = seen | a_out_valid;
            @(posedge clk); #1;
        end
        checkOutput(tag, seen, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) s_rows[i] = '0;
        for (int i = 0; i < 4; i++) d_rows[i] = '0;
`ifdef REDUCE_ROWS_FLUSH_EN
        flush = 1'b0;
`endif
        #3;
        checkOutput("rst_valid_a", a_out_valid, 0);
        checkOutput("rst_data_a", a_out_data, 0);
        checkOutput("rst_ready_a", a_in_ready, 1);
        checkOutput("rst_data_b", b_out_data, 0);
        checkOutput("rst_valid_d", d_out_valid, 0);
        checkOutput("rst_ready_d", d_in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_valid_a", a_out_valid, 0);
        checkOutput("idle_data_c", c_out_data, 0);
        checkOutput("idle_ready_b", b_in_ready, 1);

        s_rows = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h8};
        applyStimulus("dir_or");
        s_rows = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h6, 4'hF, 4'hF, 4'hF};
        applyStimulus("dir_and");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) s_rows[i] = 4'($urandom);
            applyStimulus("rand");
        end

        streamXor();

        s_out_ready = 1'b0;
        fillA(3);
        checkOutput("mid_full_valid", a_out_valid, 1);
        checkOutput("mid_full_ready", a_in_ready, 0);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_drop_valid", a_out_valid, 0);
        checkOutput("mid_drop_data", a_out_data, 0);
        @(posedge clk); #1;
        reset_n     = 1'b1;
        s_out_ready = 1'b1;
        watchA("mid_stale", 8);

`ifdef REDUCE_ROWS_FLUSH_EN
        s_out_ready = 1'b0;
        fillA(3);
        checkOutput("flush_full", a_out_valid, 1);
        flush      = 1'b1;
        s_in_valid = 1'b1;
        #1;
        checkOutput("flush_in_ready", a_in_ready, 0);
        checkOutput("flush_cycle_valid", a_out_valid, 1);
        @(posedge clk); #1;
        flush      = 1'b0;
        s_in_valid = 1'b0;
        checkOutput("flush_after_valid", a_out_valid, 0);
        checkOutput("flush_after_ready", a_in_ready, 1);
        s_out_ready = 1'b1;
        watchA("flush_no_input", 6);
        fillA(1);
        flush      = 1'b1;
        s_in_valid = 1'b1;
        #1;
        checkOutput("flush_part_ready", a_in_ready, 0);
        @(posedge clk); #1;
        flush      = 1'b0;
        s_in_valid = 1'b0;
        watchA("flush_part_gone", 6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
